// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C write master
package i2c_pkg;

  // Transaction phases; each non-idle phase is split into quarter-bit slots
  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACKSLOT,
    STOP,
    DONE
  } state_t;

  // Quarter index within a bit slot (Q0..Q3)
  typedef logic [1:0] qtr_t;

  localparam int NUM_BYTES    = 3;
  // START (4) + 3 bytes x 9 slots x 4 quarters + STOP (4)
  localparam int QTR_PER_XFER = 116;

endpackage

// File: rtl/i2c_qtick_gen.sv
// rtl/i2c_qtick_gen.sv - quarter-bit clock-enable generator
module i2c_qtick_gen #(
  parameter int QDIV = 625
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic run,
  output logic qtick
);

  localparam int W = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [W-1:0] LAST = W'(QDIV - 1);

  logic [W-1:0] count;

  // Free-run 0..QDIV-1 while enabled; parked at zero otherwise
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign qtick = run && (count == LAST);

endmodule

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - three-byte I2C write engine for the decoder config sequencer
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);

  state_t      state, state_nx;
  qtr_t        qtr;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        nack_acc;
  logic        ack_q;
  logic        qtick;
  logic        scl_d, sda_low_d;
  logic        scl_q, sda_low_q;

  i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .run   (state != IDLE),
    .qtick (qtick)
  );

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; every phase boundary falls on the Q3 quarter tick
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (iGO) state_nx = START;
      START:   if (qtick && qtr == 2'd3) state_nx = BIT;
      BIT:     if (qtick && qtr == 2'd3 && bit_cnt == 3'd7) state_nx = ACKSLOT;
      ACKSLOT: if (qtick && qtr == 2'd3)
                 state_nx = (byte_cnt == 2'(NUM_BYTES - 1)) ? STOP : BIT;
      STOP:    if (qtick && qtr == 2'd3) state_nx = DONE;
      DONE:    if (qtick && !iGO) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: quarter/bit/byte counters, shift register and NACK accumulator
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      nack_acc <= 1'b0;
      ack_q    <= 1'b0;
    end else if (state == IDLE) begin
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      if (iGO) begin
        shift    <= iDATA;
        nack_acc <= 1'b0;
        ack_q    <= 1'b0;
      end
    end else if (qtick) begin
      qtr <= qtr + 2'd1;
      if (state == BIT && qtr == 2'd3) begin
        shift   <= {shift[22:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == ACKSLOT && qtr == 2'd2) begin
        nack_acc <= nack_acc | I2C_SDAT;
      end
      if (state == ACKSLOT && qtr == 2'd3) begin
        byte_cnt <= (byte_cnt == 2'(NUM_BYTES - 1)) ? 2'd0 : byte_cnt + 2'd1;
      end
      if (state == STOP && qtr == 2'd3) begin
        ack_q <= nack_acc;
      end
    end
  end

  // Bus waveform decode per phase and quarter; SDA is only ever pulled low
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state)
      START: begin
        scl_d     = (qtr != 2'd3);
        sda_low_d = (qtr != 2'd0);
      end
      BIT: begin
        scl_d     = (qtr == 2'd1) || (qtr == 2'd2);
        sda_low_d = !shift[23];
      end
      ACKSLOT: begin
        scl_d     = (qtr == 2'd1) || (qtr == 2'd2);
      end
      STOP: begin
        scl_d     = (qtr != 2'd0);
        sda_low_d = (qtr == 2'd0) || (qtr == 2'd1);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // Register the pins so decode glitches never reach the bus
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign I2C_SCLK = scl_q;
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;
  assign oEND     = (state == DONE);
  assign oBUSY    = (state != IDLE);
  assign oACK     = ack_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - self-checking bench for i2c_write_master
module tb_i2c_write_master;

  localparam int CLK_FREQ = 400_000;
  localparam int I2C_FREQ = 20_000;
  localparam int QDIV     = CLK_FREQ / (4 * I2C_FREQ);
  localparam int XFER_CYC = 116 * QDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [23:0] data = '0;
  logic        oend, oack, obusy, scl_w;
  wire         sda_w;
  logic        slave_low = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  i2c_write_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .iCLK    (clk),
    .iRST_N  (rst_n),
    .iDATA   (data),
    .iGO     (go),
    .oEND    (oend),
    .oACK    (oack),
    .oBUSY   (obusy),
    .I2C_SCLK(scl_w),
    .I2C_SDAT(sda_w)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rise_cnt = 0, fall_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic [26:0] obs_bits = '0;
  logic [2:0]  nack_mask = '0;

  // Bus monitor: bits seen on SCL rising edges
  always @(posedge scl_w) begin
    if (rise_cnt < 27) obs_bits = {obs_bits[25:0], sda_w};
    rise_cnt++;
  end

  // Slave model: pull SDA low for the ACK slot of bytes not marked NACK
  always @(negedge scl_w) begin
    int b;
    fall_cnt++;
    b = rise_cnt / 9;
    slave_low = 1'b0;
    if ((rise_cnt % 9 == 8) && b <= 2) slave_low = !nack_mask[b];
  end

  // START / STOP detection: SDA edges while SCL is high
  always @(negedge sda_w) if (scl_w === 1'b1) start_cnt++;
  always @(posedge sda_w) if (scl_w === 1'b1) stop_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer; drop_at>0 drops GO that many cycles after accept,
  // otherwise GO is dropped on the hold_j-th cycle that oEND is seen high
  task automatic run_xfer(input string name, input logic [23:0] d, input logic [2:0] nm,
                          input int drop_at, input int hold_j);
    int k, j, jg, m;
    logic [26:0] exp_bits;
    exp_bits = {d[23:16], nm[0], d[15:8], nm[1], d[7:0], nm[2]};
    @(negedge clk);
    rise_cnt = 0; fall_cnt = 0; start_cnt = 0; stop_cnt = 0;
    obs_bits = '0; nack_mask = nm; slave_low = 1'b0;
    data = d;
    go = 1'b1;
    jg = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk({name, ".busy_at_accept"}, obusy, 1);
        data = ~d;
      end
      if (drop_at > 0 && k == drop_at) begin
        go = 1'b0;
        jg = -1;
      end
    end while (oend !== 1'b1 && k < XFER_CYC + 20);
    chk({name, ".end_latency"}, k - 1, XFER_CYC);
    chk({name, ".ack"}, oack, |nm);
    chk({name, ".bits"}, obs_bits, exp_bits);
    chk({name, ".scl_rises"}, rise_cnt, 28);
    chk({name, ".scl_falls"}, fall_cnt, 28);
    chk({name, ".starts"}, start_cnt, 1);
    chk({name, ".stops"}, stop_cnt, 1);
    j = 1;
    while (oend === 1'b1 && j < hold_j + 4 * QDIV + 20) begin
      if (go && j == hold_j) begin
        go = 1'b0;
        jg = j;
      end
      @(negedge clk);
      j++;
    end
    m = (jg <= 0) ? QDIV : ((jg + QDIV - 1) / QDIV) * QDIV;
    chk({name, ".end_len"}, j - 1, m);
    chk({name, ".busy_after"}, obusy, 0);
    chk({name, ".ack_held"}, oack, |nm);
    chk({name, ".scl_idle"}, scl_w, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [23:0] rd;
    logic [2:0]  rm;

    repeat (3) @(negedge clk);
    chk("rst.scl", scl_w, 1);
    chk("rst.sda", sda_w, 1);
    chk("rst.busy", obusy, 0);
    chk("rst.end", oend, 0);
    chk("rst.ack", oack, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer("t1", 24'h40_C3_01, 3'b000, 0, 1);
    run_xfer("t2", 24'h40_C3_01, 3'b010, 0, 1);
    run_xfer("t3", 24'h40_C3_01, 3'b000, 0, 1000);
    repeat (3 * QDIV) @(negedge clk);
    chk("t3.no_restart_busy", obusy, 0);
    chk("t3.no_restart_end", oend, 0);
    run_xfer("t4", 24'h40_C3_01, 3'b000, 10, 1);

    @(negedge clk);
    rise_cnt = 0; fall_cnt = 0; start_cnt = 0; stop_cnt = 0; nack_mask = '0;
    data = 24'h40_C3_01;
    go = 1'b1;
    k = 0;
    while (rise_cnt < 12 && k < XFER_CYC) begin
      @(negedge clk);
      k++;
    end
    #2 rst_n = 1'b0;
    go = 1'b0;
    #1;
    chk("t5.rst_scl", scl_w, 1);
    chk("t5.rst_sda", sda_w, 1);
    chk("t5.rst_busy", obusy, 0);
    chk("t5.rst_end", oend, 0);
    chk("t5.rst_ack", oack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5.idle_busy", obusy, 0);
    run_xfer("t5", 24'h40_0E_80, 3'b000, 0, 1);

    run_xfer("t6a", 24'h40_17_41, 3'b000, 0, 1);
    run_xfer("t6b", 24'h40_58_01, 3'b000, 0, 1);

    for (int i = 0; i < 3; i++) begin
      rd = 24'($urandom);
      rm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        run_xfer("rnd", rd, rm, int'($urandom_range(1, XFER_CYC - 1)), 1);
      else
        run_xfer("rnd", rd, rm, 0, int'($urandom_range(1, 3 * QDIV)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
